// File: rtl/operand2_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand2_stage
// Description : Decodes the operand-2 field into barrel-shifter a/shamt/sh,
//               fetching Rs for register-specified shifts.
// Revision    : 1.0 - initial release
// ============================================================================
module operand2_stage #(
    parameter int RS_ADDR_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 i_bit,
    input  logic [11:0]          op2,
    input  logic [31:0]          rm_data,
    input  logic                 carry_in,
    output logic                 rs_rd_en,
    output logic [RS_ADDR_W-1:0] rs_addr,
    input  logic [31:0]          rs_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          a,
    output logic [7:0]           shamt,
    output logic [1:0]           sh
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_RS = 2'd1,
        FULL     = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_accept;
    logic        w_reg_shift;
    logic [4:0]  w_imm5;
    logic [31:0] w_imm_a;
    logic [7:0]  w_imm_shamt;
    logic [1:0]  w_imm_sh;
    logic [7:0]  w_reg_shamt;
    logic [31:0] r_rm;
    logic [1:0]  r_rm_sh;
    logic        w_unused_rs_hi;

    assign in_ready    = !flush && ((r_state == IDLE) || ((r_state == FULL) && out_ready));
    assign w_accept    = in_valid && in_ready;
    assign w_reg_shift = !i_bit && op2[4];
    assign rs_rd_en    = w_accept && w_reg_shift;
    assign rs_addr     = RS_ADDR_W'(op2[11:8]);
    assign out_valid   = (r_state == FULL);
    assign w_imm5      = op2[11:7];

    // Only the low byte of Rs ever reaches the shifter.
    assign w_unused_rs_hi = ^rs_data[31:8];

    always_comb begin
        w_imm_a     = rm_data;
        w_imm_sh    = op2[6:5];
        w_imm_shamt = {3'b0, w_imm5};
        if (i_bit) begin
            w_imm_a     = {24'b0, op2[7:0]};
            w_imm_sh    = 2'b11;
            w_imm_shamt = {3'b0, op2[11:8], 1'b0};
        end else begin
            case (op2[6:5])
                2'b01, 2'b10: begin
                    if (w_imm5 == 5'd0) w_imm_shamt = 8'd32;
                end
                2'b11: begin
                    // ROR #0 encodes RRX: pre-rotate by one through carry.
                    if (w_imm5 == 5'd0) begin
                        w_imm_a     = {carry_in, rm_data[31:1]};
                        w_imm_sh    = 2'b00;
                        w_imm_shamt = 8'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_reg_shamt = (r_rm_sh == 2'b11) ? {3'b0, rs_data[4:0]} : rs_data[7:0];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) w_state_nxt = w_reg_shift ? FETCH_RS : FULL;
                end
                FETCH_RS: w_state_nxt = FULL;
                FULL: begin
                    if (w_accept)       w_state_nxt = w_reg_shift ? FETCH_RS : FULL;
                    else if (out_ready) w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a       <= 32'd0;
            shamt   <= 8'd0;
            sh      <= 2'b00;
            r_rm    <= 32'd0;
            r_rm_sh <= 2'b00;
        end else if (!flush) begin
            if (w_accept && !w_reg_shift) begin
                a     <= w_imm_a;
                shamt <= w_imm_shamt;
                sh    <= w_imm_sh;
            end else if (w_accept) begin
                r_rm    <= rm_data;
                r_rm_sh <= op2[6:5];
            end else if (r_state == FETCH_RS) begin
                a     <= r_rm;
                shamt <= w_reg_shamt;
                sh    <= r_rm_sh;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_operand2_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand2_stage
// Description : Scoreboard bench for operand2_stage with a rule-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand2_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, i_bit, carry_in;
    logic [11:0] op2;
    logic [31:0] rm_data, rs_data;
    logic        rs_rd_en, out_valid, out_ready;
    logic [3:0]  rs_addr;
    logic [31:0] a;
    logic [7:0]  shamt;
    logic [1:0]  sh;

    logic [31:0] regs [16];
    logic [41:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 1'b0;

    operand2_stage #(.RS_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .i_bit(i_bit), .op2(op2), .rm_data(rm_data),
        .carry_in(carry_in), .rs_rd_en(rs_rd_en), .rs_addr(rs_addr),
        .rs_data(rs_data), .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .shamt(shamt), .sh(sh)
    );

    always #5 clk = ~clk;

    // Synchronous register-file read port; junk when not read.
    always @(posedge clk) rs_data <= rs_rd_en ? regs[rs_addr] : $urandom;

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Expected {a, shamt, sh} from the operand-2 encoding rules.
    function automatic logic [41:0] model(input bit ib, input logic [11:0] op,
                                         input logic [31:0] rm, input bit c,
                                         input logic [31:0] rs);
        logic [31:0] ea;
        logic [1:0]  esh;
        int          es;
        int          n;
        if (ib) begin
            ea  = {24'b0, op[7:0]};
            esh = 2'd3;
            es  = 2 * int'(op[11:8]);
        end else if (op[4]) begin
            ea  = rm;
            esh = op[6:5];
            es  = (esh == 2'd3) ? int'(rs % 32) : int'(rs % 256);
        end else begin
            n   = int'(op[11:7]);
            ea  = rm;
            esh = op[6:5];
            es  = n;
            if (n == 0 && (esh == 2'd1 || esh == 2'd2)) es = 32;
            if (n == 0 && esh == 2'd3) begin
                ea  = (c ? 32'h8000_0000 : 32'h0) | (rm >> 1);
                esh = 2'd0;
                es  = 0;
            end
        end
        return {ea, es[7:0], esh};
    endfunction

    task automatic issue_op(input bit ib, input logic [11:0] op, input logic [31:0] rm,
                            input bit c, input bit chk_lat, input logic [41:0] exp_v,
                            output int waited);
        bit reg_sh;
        int lat;
        reg_sh   = !ib && op[4];
        i_bit    = ib;
        op2      = op;
        rm_data  = rm;
        carry_in = c;
        in_valid = 1'b1;
        waited   = 0;
        while (1) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 100) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: in_ready never rose for op %0h", op);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("rs_rd_en_at_accept", rs_rd_en, reg_sh);
        if (reg_sh) chk("rs_addr", rs_addr, op[11:8]);
        exp_q.push_back(exp_v);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (chk_lat) begin
            lat = 1;
            while (1) begin
                @(negedge clk);
                if (out_valid || lat > 8) break;
                if (reg_sh && lat == 1) chk("in_ready_in_fetch_rs", in_ready, 0);
                @(posedge clk); #1;
                lat++;
            end
            chk("latency", lat, reg_sh ? 2 : 1);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: pops on every handshake and checks stalled outputs stay put.
    logic [41:0] held_v;
    bit          held = 1'b0;
    always @(negedge clk) begin
        logic [41:0] e;
        if (out_valid && out_ready) begin
            if (held) chk("stall_stability", {a, shamt, sh}, held_v);
            held = 1'b0;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h expected none", {a, shamt, sh});
            end else begin
                e = exp_q.pop_front();
                chk("a", a, e[41:10]);
                chk("shamt", shamt, e[9:2]);
                chk("sh", sh, e[1:0]);
            end
        end else if (out_valid) begin
            if (held) chk("stall_stability", {a, shamt, sh}, held_v);
            held   = 1'b1;
            held_v = {a, shamt, sh};
        end else begin
            held = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        i_bit = 1'b0; op2 = 12'h0; rm_data = 32'h0; carry_in = 1'b0;
        for (int i = 0; i < 16; i++) regs[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_outputs", {a, shamt, sh}, 42'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Immediate rotate, LSR #0, RRX.
        issue_op(1, 12'h4FF, 32'h0, 0, 1, {32'h0000_00FF, 8'd8, 2'b11}, w);
        chk("imm_no_wait", w, 0);
        issue_op(0, 12'h020, 32'h8000_0000, 0, 1, {32'h8000_0000, 8'd32, 2'b01}, w);
        issue_op(0, 12'h060, 32'h0000_0003, 1, 1, {32'h8000_0001, 8'd0, 2'b00}, w);

        // Register shifts.
        regs[3] = 32'h0000_0120;
        issue_op(0, 12'h370, 32'h1234_5678, 0, 1, {32'h1234_5678, 8'd0, 2'b11}, w);
        regs[3] = 32'h0000_0104;
        issue_op(0, 12'h370, 32'h1234_5678, 0, 1, {32'h1234_5678, 8'd4, 2'b11}, w);
        regs[5] = 32'hFFFF_FF28;
        issue_op(0, 12'h510, 32'hCAFE_F00D, 0, 1, {32'hCAFE_F00D, 8'h28, 2'b00}, w);

        // Backpressure, then back-to-back accept with no bubble.
        out_ready = 1'b0;
        issue_op(1, 12'h2AB, 32'h0, 0, 0, {32'h0000_00AB, 8'd4, 2'b11}, w);
        repeat (3) begin
            @(negedge clk);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        issue_op(1, 12'h0F0, 32'h0, 0, 1, {32'h0000_00F0, 8'd0, 2'b11}, w);
        chk("accept_while_draining", w, 0);

        // Flush during FETCH_RS with another op waiting.
        i_bit = 1'b0; op2 = 12'h370; rm_data = 32'hAAAA_5555; in_valid = 1'b1;
        @(negedge clk);
        chk("flush_pre_accept", in_ready, 1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 0);
        chk("flush_rs_rd_en", rs_rd_en, 0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("flush_idle", in_ready, 1);
        @(posedge clk); #1;

        // Reset during FETCH_RS clears everything.
        op2 = 12'h370; rm_data = 32'h5555_AAAA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_fetch_out_valid", out_valid, 0);
        chk("rst_fetch_outputs", {a, shamt, sh}, 42'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_fetch_stays_empty", out_valid, 0);
        @(posedge clk); #1;

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 16; i++)
            regs[i] = (i % 3 == 0) ? 32'(i * 32) : $urandom;
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            bit          ib, c;
            logic [11:0] op;
            logic [31:0] rm;
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            ib = ($urandom_range(0, 2) == 0);
            op = 12'($urandom);
            rm = $urandom;
            c  = 1'($urandom);
            issue_op(ib, op, rm, c, 0, model(ib, op, rm, c, regs[op[11:8]]), w);
        end
        rand_ready = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
